// File: rtl/instr_sequencer_if.sv
//------------------------------------------------------------------------------
// instr_sequencer_if : sequencer <-> ROM/LUT/datapath signal bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instr_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             Start;
    logic [8:0]       Mach_code;
    logic [PC_W-1:0]  Jump_tgt;
    logic             Zero;
    logic             Mem_ack;
    logic [PC_W-1:0]  Prog_ctr;
    logic [8:0]       Instr;
    logic             Alu_en;
    logic             Mem_req;
    logic             Mem_we;
    logic             Reg_we;
    logic             Done;
    logic             Fault;
    logic [CNT_W-1:0] Cycle_cnt;

    modport master (
        input  Start, Mach_code, Jump_tgt, Zero, Mem_ack,
        output Prog_ctr, Instr, Alu_en, Mem_req, Mem_we, Reg_we, Done, Fault, Cycle_cnt
    );

    modport slave (
        output Start, Mach_code, Jump_tgt, Zero, Mem_ack,
        input  Prog_ctr, Instr, Alu_en, Mem_req, Mem_we, Reg_we, Done, Fault, Cycle_cnt
    );
endinterface

`default_nettype wire

// File: rtl/instr_sequencer.sv
//------------------------------------------------------------------------------
// instr_sequencer : multi-cycle fetch/decode/execute sequencer for the 9-bit core
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_sequencer #(
    parameter int PC_W        = 10,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  wire logic          Clk,
    input  wire logic          Reset_n,
    instr_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [7:0] c_TIMEOUT = 8'(MEM_TIMEOUT);

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic [8:0]       r_ir;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tcnt;

    logic             w_halt, w_load, w_alu, w_nop, w_store, w_branch;
    logic [PC_W-1:0]  w_pc_inc;
    logic [7:0]       w_tcnt_inc;
    logic             w_counting;

    // Class decode is priority ordered: 9'h1FF would otherwise look like a load.
    assign w_halt   = (r_ir == 9'h1FF);
    assign w_load   = !w_halt && (r_ir[7:6] == 2'b11);
    assign w_alu    = (r_ir[7:6] == 2'b01);
    assign w_nop    = (r_ir[7:6] == 2'b10);
    assign w_store  = (r_ir[8:6] == 3'b000);
    assign w_branch = (r_ir[8:6] == 3'b100);

    assign w_pc_inc   = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign w_tcnt_inc = r_tcnt + 8'd1;
    assign w_counting = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                        (r_state == S_EXEC)  || (r_state == S_MEM)    ||
                        (r_state == S_WB);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_cnt   <= '0;
            r_tcnt  <= '0;
        end else begin
            if (w_counting && (r_cnt != '1)) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (bus.Start) begin
                        r_pc    <= '0;
                        r_cnt   <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_ir    <= bus.Mach_code;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_state <= w_halt ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    if (w_branch) begin
                        r_pc    <= bus.Zero ? bus.Jump_tgt : w_pc_inc;
                        r_state <= S_FETCH;
                    end else if (w_nop) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_FETCH;
                    end else if (w_alu) begin
                        r_state <= S_WB;
                    end else begin
                        r_tcnt  <= '0;
                        r_state <= S_MEM;
                    end
                end
                S_MEM: begin
                    // An ack arriving on the final timeout cycle still completes normally.
                    if (bus.Mem_ack) begin
                        if (w_load) begin
                            r_state <= S_WB;
                        end else begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end
                    end else if (w_tcnt_inc == c_TIMEOUT) begin
                        r_tcnt  <= w_tcnt_inc;
                        r_state <= S_FAULT;
                    end else begin
                        r_tcnt  <= w_tcnt_inc;
                    end
                end
                S_WB: begin
                    r_pc    <= w_pc_inc;
                    r_state <= S_FETCH;
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register so reset removes them immediately.
    assign bus.Prog_ctr  = r_pc;
    assign bus.Instr     = r_ir;
    assign bus.Cycle_cnt = r_cnt;
    assign bus.Alu_en    = (r_state == S_EXEC);
    assign bus.Mem_req   = (r_state == S_MEM);
    assign bus.Mem_we    = (r_state == S_MEM) && w_store;
    assign bus.Reg_we    = (r_state == S_WB);
    assign bus.Done      = (r_state == S_HALT);
    assign bus.Fault     = (r_state == S_FAULT);

endmodule

`default_nettype wire
